// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants. Holds the receiver FSM
//                state encoding, the ASCII command bytes understood by the
//                downstream command decoder, and the baud divider helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // ASCII command bytes recognised by the command decoder
  localparam logic [7:0] CMD_READ  = 8'h72;  // "r"
  localparam logic [7:0] CMD_CLEAR = 8'h63;  // "c"
  localparam logic [7:0] CMD_MODE  = 8'h6D;  // "m"

  // Clocks per oversampling tick, clamped to at least one clock.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    int div;
    div = clk_freq / (baud * ovs);
    return (div < 1) ? 1 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Free-running oversampling tick generator. A counter runs
//                0..DIV-1 with DIV = CLK_FREQ/(BAUD*OVS); tick is high for
//                the one clock in which the counter holds DIV-1.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                tick - one-clock pulse every DIV clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with OVS-times oversampling. The line is
//                synchronised, the start bit is verified at its midpoint,
//                data bits are sampled every OVS ticks (LSB first) and the
//                stop bit decides between rx_done and frame_err.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                rx        - asynchronous serial input, idle high
//                rx_data   - last correctly received byte (held)
//                rx_done   - one-clock strobe, rx_data valid same cycle
//                rx_busy   - high while a frame is in progress
//                frame_err - one-clock strobe on a low stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int TCW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVS - 1);

  logic tick;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  uart_rx_state_t state_q, state_d;
  logic [1:0]     sync_q, sync_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_done_q, rx_done_d;
  logic           frame_err_q, frame_err_d;
  // Cleared by a framing error so a held-low line (break) cannot start a
  // new frame until the line has been seen high again in IDLE.
  logic           armed_q, armed_d;
  logic           rx_s;

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;

    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_idx_d  = 3'd0;
            // A line that is high again at mid start bit was a glitch.
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. Runs with
//                DIV = 4 clocks per tick and 16 ticks per bit, so one bit
//                lasts 64 clocks and a frame 640 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ = 640;
  localparam int BAUD     = 10;
  localparam int OVS      = 16;
  localparam int DIV      = 4;
  localparam int BIT      = DIV * OVS;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .OVS      (OVS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  int         cyc       = 0;
  int         done_cnt  = 0;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         long_cnt  = 0;
  int         done_cyc  = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] data_log [16];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done) begin
        if (done_cnt < 16) data_log[done_cnt] = rx_data;
        done_cnt++;
        done_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (rx_done && frame_err) both_cnt++;
      if ((rx_done && prev_done) || (frame_err && prev_ferr)) long_cnt++;
    end
    prev_done = rx_done;
    prev_ferr = frame_err;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int start_cyc = 0;

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      wait_clks(BIT);
    end
  endtask

  int d0, f0, lat;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    @(negedge clk);
    check("reset_rx_data",   {24'h0, rx_data}, 32'h00);
    check("reset_rx_done",   {31'h0, rx_done}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_rx_busy",   {31'h0, rx_busy}, 32'h0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(100);

    // Single valid frame: "r"
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h72, 1'b1);
    lat = done_cyc - start_cyc;
    wait_clks(20);
    check("r_done_count", done_cnt - d0, 1);
    check("r_data_log",   {24'h0, data_log[d0]}, 32'h72);
    check("r_rx_data",    {24'h0, rx_data}, 32'h72);
    check("r_no_ferr",    ferr_cnt - f0, 0);
    check("r_latency_ok", (lat >= 9 * BIT) && (lat <= 10 * BIT + 3), 1);

    // Back-to-back "c" then "m", no idle gap
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h63, 1'b1);
    send_byte(8'h6D, 1'b1);
    wait_clks(20);
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_first",      {24'h0, data_log[d0]}, 32'h63);
    check("b2b_second",     {24'h0, data_log[d0 + 1]}, 32'h6D);
    check("b2b_no_ferr",    ferr_cnt - f0, 0);

    // Three-tick low glitch on an idle line
    d0 = done_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(10);
    check("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
    wait_clks(3 * DIV - 10);
    rx = 1'b1;
    wait_clks(45 - 3 * DIV);
    check("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
    wait_clks(700);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // 0x55 with a low stop bit
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    rx = 1'b1;
    wait_clks(20);
    check("ferr_count",   ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_hold",    {24'h0, rx_data}, 32'h6D);

    // Reset in the middle of data bit 3 of 0xA5, held to the stop bit
    d0 = done_cnt; f0 = ferr_cnt;
    begin
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
        rx = frame[i];
        for (int c = 0; c < BIT; c++) begin
          if (i == 4 && c == BIT / 2) rst = 1'b1;
          if (i == 9 && c == 10) rst = 1'b0;
          wait_clks(1);
        end
      end
    end
    wait_clks(20);
    check("rst_no_done",   done_cnt - d0, 0);
    check("rst_no_ferr",   ferr_cnt - f0, 0);
    check("rst_data_zero", {24'h0, rx_data}, 32'h00);
    send_byte(8'h3C, 1'b1);
    wait_clks(20);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_data", {24'h0, rx_data}, 32'h3C);

    // Tick period across 1000 intervals
    begin
      int last_t, n, bad;
      last_t = -1; n = 0; bad = 0;
      for (int k = 0; k < 6000 && n < 1001; k++) begin
        @(negedge clk);
        if (dut.tick) begin
          if (last_t >= 0 && (cyc - last_t) != DIV) bad++;
          last_t = cyc;
          n++;
        end
      end
      check("tick_count",   n, 1001);
      check("tick_spacing", bad, 0);
    end

    check("strobe_overlap", both_cnt, 0);
    check("strobe_width",   long_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter OVS, default 16, oversampling ticks per bit.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  last correctly received byte.
REQ-008 SHALL have port rx_done  output  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is in progress, from start-edge detection to the end of the stop bit.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe when the stop bit is sampled low.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 SHALL generate tick, a 1-cycle pulse every DIV = CLK_FREQ/(BAUD*OVS) clocks (integer division; 651 at the defaults), using a free-running counter 0..DIV-1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized rx = 0, SHALL go to START, clear the tick count, and assert rx_busy from the next cycle.
REQ-015 START: after OVS/2 ticks (mid start bit), if rx = 0 SHALL go to DATA with tick count cleared; if rx = 1 SHALL treat the event as a glitch and return to IDLE with no strobe.
REQ-016 DATA: SHALL sample rx every OVS ticks and shift it in LSB first, using a 3-bit bit index; after the 8th sample SHALL go to STOP.
REQ-017 STOP: after OVS ticks, SHALL act on the sampled stop bit:
- rx = 1: update rx_data with the shift register and pulse rx_done for exactly one clk.
- rx = 0: pulse frame_err for one clk and leave rx_data unchanged.
- In both cases, SHALL return to IDLE.
REQ-018 rx_done and frame_err SHALL never both be high, and neither SHALL be high for more than one cycle per frame.
REQ-019 rx_data SHALL hold its value between frames.
REQ-020 Once the FSM has returned to IDLE, SHALL accept a new start bit immediately; back-to-back frames with no idle gap SHALL be received without loss.
REQ-021 Timing: rx_done SHALL assert within 10 bit times + 3 clk of the falling start edge at the rx pin.
REQ-022 rx low held longer than one frame (break condition) SHALL yield frame_err, then re-arm only after rx has been seen high in IDLE.

Reset
REQ-023 On rst = 1 at a clk edge, SHALL force: FSM = IDLE, all counters = 0, shift register = 0, rx_data = 8'h00, rx_done = 0, frame_err = 0, rx_busy = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no strobe; reception SHALL resume from the next valid start bit after release.

Structure
REQ-025 SHALL place the FSM state enum (uart_rx_state_t) and the ASCII command constants "r", "c", "m" in a shared package uart_pkg, also used by the command decoder downstream.
REQ-026 SHALL implement the tick generator as sub-module baud_tick_gen (parameters CLK_FREQ, BAUD, OVS; ports clk, rst, tick).
REQ-027 Total RTL SHALL be roughly 120-250 lines.

Verification
REQ-028 The bench SHALL cover these scenarios; it MAY override CLK_FREQ/BAUD (e.g. DIV = 4) to shorten simulation.
- Send 0x72 ("r") with a valid stop bit -> one rx_done pulse, rx_data = 8'h72, frame_err stays 0.
- Send 0x63 then 0x6D back-to-back, no idle gap -> two rx_done pulses, with rx_data = 8'h63 then 8'h6D.
- Drive a 3-tick low glitch on idle rx -> return to IDLE, no rx_done, no frame_err, rx_busy deasserts by mid start bit.
- Send 0x55 with the stop bit driven low -> one frame_err pulse, no rx_done, rx_data keeps its previous value.
- Assert rst during the 4th data bit of 0xA5, then send 0x3C -> no strobe for 0xA5, rx_done with rx_data = 8'h3C.
- Check period: tick pulse spacing = DIV clocks exactly, every pulse, across 1000 ticks.
